// File: rtl/sha256_pkg.sv
// ============================================================================
// sha256_pkg : shared SHA-256 front-end types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

    localparam int SHA256_BLOCK_W     = 512;
    localparam int SHA256_WORD_W      = 32;
    localparam int SHA256_LEN_FIELD_W = 64;

    localparam logic [SHA256_WORD_W-1:0] PAD_MARKER = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_LEN  = 2'd1,
        ST_EMIT = 2'd2
    } pad_state_t;

endpackage

`default_nettype wire

// File: rtl/sha256_last_word_mask.sv
// ============================================================================
// sha256_last_word_mask : keeps the top n bytes of the final word, appends 0x80
// Rev 1.0
// ============================================================================
`default_nettype none

module sha256_last_word_mask
    import sha256_pkg::*;
(
    input  logic [SHA256_WORD_W-1:0] data,
    input  logic [2:0]               nbytes,
    output logic [SHA256_WORD_W-1:0] word,
    output logic                     full
);

    always_comb begin
        word = '0;
        full = (nbytes >= 3'd4);
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes) begin
                word[31-8*i -: 8] = data[31-8*i -: 8];
            end else if (3'(i) == nbytes) begin
                word[31-8*i -: 8] = 8'h80;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sha256_msg_pad.sv
// ============================================================================
// sha256_msg_pad : packs a 32-bit word stream into padded 512-bit SHA-256 blocks
// Rev 1.0
// ============================================================================
`default_nettype none

module sha256_msg_pad
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SHA256_WORD_W-1:0]  s_data,
    input  logic                      s_last,
    input  logic [2:0]                s_nbytes,
    output logic [SHA256_BLOCK_W-1:0] m_block,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_first,
    output logic                      m_last,
    output logic                      busy
);

    pad_state_t r_state;
    pad_state_t w_state_nxt;

    logic [SHA256_WORD_W-1:0]      r_buf [16];
    logic [4:0]                    r_widx;
    logic [LEN_W-1:0]              r_len;
    logic                          r_first;
    logic                          r_mark_pend;
    logic                          r_last;
    logic                          r_pad_cont;

    logic                          w_accept;
    logic [SHA256_WORD_W-1:0]      w_last_word;
    logic                          w_last_full;
    logic [2:0]                    w_nclamp;
    logic                          w_mark_here;
    logic [4:0]                    w_p_after;
    logic                          w_len_fits;
    logic [SHA256_LEN_FIELD_W-1:0] w_len64;

    sha256_last_word_mask u_mask (
        .data   (s_data),
        .nbytes (s_nbytes),
        .word   (w_last_word),
        .full   (w_last_full)
    );

    assign w_accept    = s_valid && s_ready;
    assign w_nclamp    = (s_nbytes > 3'd4) ? 3'd4 : s_nbytes;
    // r_widx doubles as the next-free-word pointer once the last word is in
    assign w_mark_here = r_mark_pend && (r_widx <= 5'd15);
    assign w_p_after   = r_widx + {4'b0, w_mark_here};
    assign w_len_fits  = (w_p_after <= 5'd14);

    always_comb begin
        w_len64 = '0;
        w_len64[LEN_W-1:0] = r_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FILL;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            ST_FILL: begin
                s_ready = 1'b1;
                if (w_accept) begin
                    if (s_last)                  w_state_nxt = ST_LEN;
                    else if (r_widx == 5'd15)    w_state_nxt = ST_EMIT;
                end
            end
            ST_LEN:  w_state_nxt = ST_EMIT;
            ST_EMIT: begin
                m_valid = 1'b1;
                if (m_ready) w_state_nxt = r_pad_cont ? ST_LEN : ST_FILL;
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_buf[i] <= '0;
            r_widx      <= '0;
            r_len       <= '0;
            r_first     <= 1'b1;
            r_mark_pend <= 1'b0;
            r_last      <= 1'b0;
            r_pad_cont  <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        r_widx <= r_widx + 5'd1;
                        if (s_last) begin
                            r_buf[r_widx[3:0]] <= w_last_word;
                            r_len              <= r_len + (LEN_W'(w_nclamp) << 3);
                            r_mark_pend        <= w_last_full;
                        end else begin
                            r_buf[r_widx[3:0]] <= s_data;
                            r_len              <= r_len + LEN_W'(32);
                        end
                    end
                end
                ST_LEN: begin
                    if (w_mark_here) begin
                        r_buf[r_widx[3:0]] <= PAD_MARKER;
                        r_mark_pend        <= 1'b0;
                    end
                    r_widx <= w_p_after;
                    if (w_len_fits) begin
                        r_buf[14]  <= w_len64[63:32];
                        r_buf[15]  <= w_len64[31:0];
                        r_last     <= 1'b1;
                        r_pad_cont <= 1'b0;
                    end else begin
                        r_last     <= 1'b0;
                        r_pad_cont <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (m_ready) begin
                        for (int i = 0; i < 16; i++) r_buf[i] <= '0;
                        r_widx     <= '0;
                        r_first    <= r_last;
                        r_last     <= 1'b0;
                        r_pad_cont <= 1'b0;
                        if (r_last) r_len <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign m_block[SHA256_BLOCK_W-1-SHA256_WORD_W*g -: SHA256_WORD_W] = r_buf[g];
    end

    assign m_first = r_first;
    assign m_last  = r_last;
    assign busy    = !((r_state == ST_FILL) && (r_widx == 5'd0) && r_first);

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_pad.sv
// ============================================================================
// tb_sha256_msg_pad : byte-level padding model vs. DUT, tables plus random msgs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sha256_msg_pad;

    typedef logic [511:0] blk_t;

    typedef struct {
        int len;
        bit split;
        int pct;
        int exp_blocks;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic [2:0]   s_nbytes;
    blk_t         m_block;
    logic         m_valid;
    logic         m_ready;
    logic         m_first;
    logic         m_last;
    logic         busy;

    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] msg[$];
    blk_t exp_q[$];
    blk_t got_q[$];

    always #5 clk = ~clk;

    sha256_msg_pad #(.LEN_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_nbytes (s_nbytes),
        .m_block  (m_block),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_first  (m_first),
        .m_last   (m_last),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Padding model: append 0x80, zero to 56 mod 64, 64-bit bit length.
    function automatic void build_model();
        logic [7:0]  pad[$];
        logic [63:0] bits;
        blk_t        b;
        pad  = msg;
        bits = 64'(msg.size()) * 64'd8;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
        exp_q.delete();
        for (int k = 0; k < pad.size() / 64; k++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = pad[64*k+j];
            exp_q.push_back(b);
        end
    endfunction

    task automatic drive_word(input logic [31:0] d, input bit last, input logic [2:0] n);
        int t;
        t        = 0;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        s_nbytes = last ? n : 3'($urandom_range(0, 7));
        while (!s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_err++;
            $display("FAIL drive_timeout: s_ready got 0 expected 1");
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_msg(input bit split);
        int         len;
        int         nw;
        int         n;
        bit         tail_empty;
        logic [31:0] d;
        len        = msg.size();
        nw         = (len + 3) / 4;
        tail_empty = (len == 0) || (split && (len % 4 == 0));
        for (int w = 0; w < nw; w++) begin
            d = $urandom;
            n = len - 4 * w;
            if (n > 4) n = 4;
            for (int b = 0; b < n; b++) d[31-8*b -: 8] = msg[4*w+b];
            drive_word(d, !tail_empty && (w == nw - 1), 3'(n));
        end
        if (tail_empty) drive_word($urandom, 1'b1, 3'd0);
    endtask

    task automatic collect(input string name, input int pct, output int nblk);
        int idx;
        int t;
        bit done;
        idx  = 0;
        t    = 0;
        done = 1'b0;
        got_q.delete();
        while (!done && t < 3000) begin
            m_ready = ($urandom_range(0, 99) < pct);
            if (m_valid && m_ready) begin
                got_q.push_back(m_block);
                chk($sformatf("%s_blk%0d", name, idx), m_block, exp_q[idx]);
                chk($sformatf("%s_flags%0d", name, idx), {m_first, m_last},
                    {idx == 0, idx == exp_q.size() - 1});
                done = m_last;
                idx++;
            end
            @(negedge clk);
            t++;
        end
        m_ready = 1'b0;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: blocks got %0d expected %0d", name, idx, exp_q.size());
        end
        nblk = idx;
    endtask

    task automatic run_msg(input string name, input int pct, input bit split, output int nblk);
        int nb;
        build_model();
        fork
            send_msg(split);
            collect(name, pct, nb);
        join
        nblk = nb;
    endtask

    task automatic do_abc(input string tag);
        blk_t e;
        e            = '0;
        e[511:480]   = 32'h61626380;
        e[31:0]      = 32'h00000018;
        m_ready      = 1'b1;
        s_valid      = 1'b1;
        s_data       = 32'h61626300;
        s_last       = 1'b1;
        s_nbytes     = 3'd3;
        chk({tag, "_sready"}, s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        chk({tag, "_lat1"}, m_valid, 0);
        @(negedge clk);
        chk({tag, "_lat2"}, m_valid, 1);
        chk({tag, "_blk"}, m_block, e);
        chk({tag, "_flags"}, {m_first, m_last}, 2'b11);
        @(negedge clk);
        m_ready = 1'b0;
        chk({tag, "_idle"}, {m_valid, busy, m_first}, 3'b001);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        int   nblk;
        int   t;

        tbl = '{
            '{0,   0, 100, 1}, '{1,   0, 100, 1}, '{4,   0,  50, 1},
            '{4,   1, 100, 1}, '{55,  0, 100, 1}, '{56,  1,  60, 2},
            '{60,  0, 100, 2}, '{62,  0,  40, 2}, '{63,  0, 100, 2},
            '{64,  1, 100, 2}, '{119, 0,  70, 2}, '{120, 0, 100, 3},
            '{128, 1,  50, 3}, '{128, 0, 100, 3}
        };

        rst_n    = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        s_nbytes = '0;
        m_ready  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_ctl", {s_ready, m_valid, m_first, m_last, busy}, 5'b10100);
        chk("reset_blk", m_block, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_abc("abc");

        msg.delete();
        run_msg("empty", 100, 1'b0, nblk);
        chk("empty_const", got_q[0], {32'h80000000, 480'h0});

        msg.delete();
        for (int i = 0; i < 56; i++) msg.push_back(8'(i + 1));
        run_msg("m56", 100, 1'b0, nblk);
        chk("m56_w14w15", got_q[0][63:0], 64'h80000000_00000000);
        chk("m56_b1_const", got_q[1], 512'h1C0);

        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'(8'hA0 ^ i));
        run_msg("m64", 100, 1'b0, nblk);
        chk("m64_b1_const", got_q[1], {32'h80000000, 448'h0, 32'h200});

        foreach (tbl[k]) begin
            msg.delete();
            for (int i = 0; i < tbl[k].len; i++) msg.push_back(8'($urandom));
            run_msg($sformatf("tbl%0d", k), tbl[k].pct, tbl[k].split, nblk);
            chk($sformatf("tbl%0d_nblk", k), nblk, tbl[k].exp_blocks);
        end

        // Backpressure: hold m_ready low with a new word waiting upstream.
        msg = '{8'h61, 8'h62, 8'h63};
        build_model();
        m_ready = 1'b0;
        drive_word(32'h616263AA, 1'b1, 3'd3);
        t = 0;
        while (!m_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid", m_valid, 1);
        s_valid  = 1'b1;
        s_data   = 32'hDEADBEEF;
        s_last   = 1'b1;
        s_nbytes = 3'd4;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold_blk", m_block, exp_q[0]);
            chk("bp_hold_ctl", {m_valid, s_ready, m_first, m_last}, 4'b1011);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("bp_release", {m_valid, busy, s_ready}, 3'b001);

        // Reset part-way through a message.
        for (int i = 0; i < 5; i++) drive_word($urandom, 1'b0, 3'd0);
        chk("rst_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {s_ready, m_valid, m_first, m_last, busy}, 5'b10100);
        chk("rst_mid_blk", m_block, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a block is being offered.
        m_ready = 1'b0;
        drive_word(32'h61626300, 1'b1, 3'd3);
        t = 0;
        while (!m_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rst_emit_pre", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_emit_ctl", {s_ready, m_valid, m_first, m_last, busy}, 5'b10100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_abc("abc_after_rst");

        for (int r = 0; r < 16; r++) begin
            msg.delete();
            for (int i = 0; i < int'($urandom_range(0, 140)); i++) msg.push_back(8'($urandom));
            run_msg($sformatf("rnd%0d", r), int'($urandom_range(30, 100)),
                    1'($urandom_range(0, 1)), nblk);
            chk($sformatf("rnd%0d_nblk", r), nblk, exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
